branch_resolve_unit: RTL and testbench

- Parametrised branch resolution and prediction block for the pipelined RISC-V core.
- Resolves conditional branches in EX: XLEN-wide compare selected by funct3, then target selection.
- Keeps a DEPTH-entry bimodal branch history table (BHT) of 2-bit saturating counters, read in IF and trained in EX.
- Outputs are registered: one-cycle mispredict/redirect to the hazard unit, plus a saturating mispredict counter.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/branch_cmp.sv | 40 ++++
 rtl/branch_resolve_unit.sv | 91 +++++++++
 tb/tb_branch_resolve_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared branch funct3 codes and BHT counter encodings
package riscv_pkg;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bht_ctr_t;

  localparam bht_ctr_t BHT_RESET = WNT;

endpackage

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - combinational branch compare flags and funct3 decode
module branch_cmp
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      f3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            cond,
  output logic            illegal
);

  logic [XLEN:0]   sum;
  logic [XLEN-1:0] diff;
  logic            cf, zf, sf, vf;

  // a - b as a + ~b + 1; cf set means no borrow (a >= b unsigned)
  assign sum  = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
  assign cf   = sum[XLEN];
  assign diff = sum[XLEN-1:0];
  assign zf   = (diff == '0);
  assign sf   = diff[XLEN-1];
  assign vf   = a[XLEN-1] ^ ~b[XLEN-1] ^ diff[XLEN-1] ^ cf;

  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (f3)
      F3_BEQ:  cond = zf;
      F3_BNE:  cond = !zf;
      F3_BLT:  cond = (sf != vf);
      F3_BGE:  cond = (sf == vf);
      F3_BLTU: cond = !cf;
      F3_BGEU: cond = cf;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX branch resolution with bimodal BHT prediction in IF
module branch_resolve_unit
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_kill,
  input  logic [2:0]       ex_f3,
  input  logic [XLEN-1:0]  ex_a,
  input  logic [XLEN-1:0]  ex_b,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic             ex_pred_taken,
  output logic             res_valid,
  output logic             res_taken,
  output logic             res_mispredict,
  output logic             res_illegal,
  output logic [XLEN-1:0]  res_target,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [1:0]       bht [DEPTH];
  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [1:0]       ctr, ctr_next;
  logic             cond, illegal, acc, mis;
  logic             unused_if_pc;

  assign unused_if_pc  = ^if_pc;
  assign if_idx        = if_pc[IDX_W+1:2];
  assign ex_idx        = ex_pc[IDX_W+1:2];
  assign if_pred_taken = bht[if_idx][1];

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .f3      (ex_f3),
    .a       (ex_a),
    .b       (ex_b),
    .cond    (cond),
    .illegal (illegal)
  );

  assign acc = ex_valid & ~ex_kill;
  assign mis = (cond != ex_pred_taken) & ~illegal;

  always_comb begin
    ctr      = bht[ex_idx];
    ctr_next = ctr;
    if (cond) begin
      if (ctr != ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != SNT) ctr_next = ctr - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bht[i] <= BHT_RESET;
    end else if (acc && !illegal) begin
      bht[ex_idx] <= ctr_next;
    end
  end

  // res_target holds across idle cycles so a late consumer still sees the last redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid        <= 1'b0;
      res_taken        <= 1'b0;
      res_mispredict   <= 1'b0;
      res_illegal      <= 1'b0;
      res_target       <= '0;
      mispredict_count <= '0;
    end else begin
      res_valid      <= acc;
      res_taken      <= acc & cond;
      res_mispredict <= acc & mis;
      res_illegal    <= acc & illegal;
      if (acc) res_target <= cond ? ex_pc + ex_imm : ex_pc + XLEN'(4);
      if (acc && mis && mispredict_count != '1)
        mispredict_count <= mispredict_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed and random checks against a behavioural branch model
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 64;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [XLEN-1:0]  if_pc;
  logic             if_pred_taken;
  logic             ex_valid, ex_kill, ex_pred_taken;
  logic [2:0]       ex_f3;
  logic [XLEN-1:0]  ex_a, ex_b, ex_pc, ex_imm;
  logic             res_valid, res_taken, res_mispredict, res_illegal;
  logic [XLEN-1:0]  res_target;
  logic [CNT_W-1:0] mispredict_count;

  branch_resolve_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .ex_valid         (ex_valid),
    .ex_kill          (ex_kill),
    .ex_f3            (ex_f3),
    .ex_a             (ex_a),
    .ex_b             (ex_b),
    .ex_pc            (ex_pc),
    .ex_imm           (ex_imm),
    .ex_pred_taken    (ex_pred_taken),
    .res_valid        (res_valid),
    .res_taken        (res_taken),
    .res_mispredict   (res_mispredict),
    .res_illegal      (res_illegal),
    .res_target       (res_target),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference state: predictor strength per entry and expected registered outputs
  int          m_bht [DEPTH];
  int          m_cnt;
  logic        e_valid, e_taken, e_mis, e_ill;
  logic [31:0] e_target;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic logic taken_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
    m_cnt = 0;
    e_valid = 0; e_taken = 0; e_mis = 0; e_ill = 0; e_target = 0;
  endtask

  task automatic check_res(input string tag);
    chk({tag, ".valid"},  32'(res_valid),        32'(e_valid));
    chk({tag, ".taken"},  32'(res_taken),        32'(e_taken));
    chk({tag, ".mis"},    32'(res_mispredict),   32'(e_mis));
    chk({tag, ".ill"},    32'(res_illegal),      32'(e_ill));
    chk({tag, ".target"}, res_target,            e_target);
    chk({tag, ".count"},  32'(mispredict_count), 32'(m_cnt));
  endtask

  // one branch per cycle: prediction checked before the edge, results one cycle later
  task automatic step(input string tag, input logic v, input logic k, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                      input logic [31:0] imm, input logic pred, input logic [31:0] ipc);
    logic t, ill;
    ex_valid = v; ex_kill = k; ex_f3 = f3; ex_a = a; ex_b = b;
    ex_pc = pc; ex_imm = imm; ex_pred_taken = pred; if_pc = ipc;
    #1;
    chk({tag, ".pred"}, 32'(if_pred_taken), 32'(m_bht[idx_of(ipc)] >= 2));
    @(posedge clk);
    t   = taken_of(f3, a, b);
    ill = (f3 == 3'd2 || f3 == 3'd3);
    if (v && !k) begin
      e_valid = 1; e_taken = t; e_ill = ill;
      e_mis = !ill && (t != pred);
      e_target = t ? pc + imm : pc + 32'd4;
      if (e_mis && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (!ill) m_bht[idx_of(pc)] = t ? ((m_bht[idx_of(pc)] == 3) ? 3 : m_bht[idx_of(pc)] + 1)
                                      : ((m_bht[idx_of(pc)] == 0) ? 0 : m_bht[idx_of(pc)] - 1);
    end else begin
      e_valid = 0; e_taken = 0; e_mis = 0; e_ill = 0;
    end
    #1;
    check_res(tag);
  endtask

  initial begin
    logic [31:0] ra, rb, rpc, ipc;
    rst = 1; if_pc = 32'h100; ex_valid = 0; ex_kill = 0; ex_f3 = 0;
    ex_a = 0; ex_b = 0; ex_pc = 0; ex_imm = 0; ex_pred_taken = 0;
    model_reset();
    #12;
    chk("reset.pred", 32'(if_pred_taken), 32'd0);
    check_res("reset");
    rst = 0;
    @(posedge clk); #1;

    // asynchronous reset in the middle of an accepted branch
    step("pre_rst", 1, 0, 3'd4, 32'hFFFFFFFF, 32'd1, 32'h40, 32'h20, 0, 32'h40);
    ex_valid = 1;
    #2 rst = 1;
    #1;
    model_reset();
    check_res("async_rst");
    @(posedge clk); #1;
    check_res("rst_edge");
    rst = 0;

    step("blt",  1, 0, 3'd4, 32'hFFFFFFFF, 32'd1, 32'h40, 32'h20, 0, 32'h100);
    chk("blt.target_lit", res_target, 32'h60);
    step("bltu", 1, 0, 3'd6, 32'hFFFFFFFF, 32'd1, 32'h40, 32'h20, 0, 32'h100);
    chk("bltu.target_lit", res_target, 32'h44);

    for (int i = 0; i < 4; i++) step("train_t", 1, 0, 3'd0, 32'd7, 32'd7, 32'h80, 32'h10, 1, 32'h80);
    #1 chk("train_t.sat", 32'(if_pred_taken), 32'd1);
    for (int i = 0; i < 4; i++) step("train_nt", 1, 0, 3'd0, 32'd7, 32'd8, 32'h80, 32'h10, 0, 32'h80);
    #1 chk("train_nt.sat", 32'(if_pred_taken), 32'd0);

    step("kill",    1, 1, 3'd0, 32'd1, 32'd1, 32'h80, 32'h10, 0, 32'h80);
    step("idle",    0, 0, 3'd0, 32'd1, 32'd1, 32'h80, 32'h10, 0, 32'h80);
    step("illegal", 1, 0, 3'd3, 32'd1, 32'd1, 32'h80, 32'h10, 1, 32'h80);
    step("after",   0, 0, 3'd0, 32'd0, 32'd0, 32'h0,  32'h0,  0, 32'h80);

    step("alias0", 1, 0, 3'd1, 32'd1, 32'd2, 32'h004, 32'h8, 0, 32'h104);
    step("alias1", 1, 0, 3'd1, 32'd1, 32'd2, 32'h107, 32'h8, 1, 32'h104);
    step("collide", 1, 0, 3'd5, 32'd3, 32'd2, 32'h104, 32'h8, 1, 32'h104);

    for (int i = 0; i < 5; i++) step("cnt_sat", 1, 0, 3'd7, 32'd5, 32'd4, 32'h200, 32'h8, 0, 32'h200);
    chk("cnt_sat.lit", 32'(mispredict_count), 32'd3);
    step("wrap", 1, 0, 3'd0, 32'd9, 32'd9, 32'hFFFFFFF0, 32'h20, 1, 32'h0);
    chk("wrap.lit", res_target, 32'h10);

    rst = 1; #1; model_reset(); rst = 0;
    for (int i = 0; i < 400; i++) begin
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      rpc = ($urandom_range(0, 7) == 0) ? $urandom
            : (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      ipc = ($urandom_range(0, 2) == 0) ? rpc : (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      step("rand", $urandom_range(0, 4) != 0, $urandom_range(0, 5) == 0, 3'($urandom_range(0, 7)),
           ra, rb, rpc, $urandom, 1'($urandom_range(0, 1)), ipc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
